// File: rtl/attempt_driver.sv
// attempt_driver
// Host-side initiator for the byte-attempt / echo exchange. Sweeps a range of
// 8-bit attempt values. Each attempt is sent to a local uart over AXI-stream,
// and the echoed byte is awaited. While waiting, the block counts the cycles in
// which the target's TGR line is high. It keeps the attempt with the longest
// TGR window, and counts echo mismatches and lost echoes.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       one-cycle pulse; accepted only in IDLE or DONE
//   sweep_first, sweep_last     inclusive sweep range, sampled on accepted start
//   tgr                         target trigger line (already in clk domain)
//   m_axis_tdata/tvalid/tready  attempt byte towards uart input stream
//   s_axis_tdata/tvalid/tready  echo byte from uart output stream
//   busy                        high while a sweep is in progress (SEND/WAIT/EVAL)
//   done                        high once the sweep finished, until next start
//   best_attempt, best_len      attempt with the longest TGR window and its length
//   err_count                   echo mismatches + timeouts, saturating at 255
//   timeout_seen                sticky flag for any lost echo during the sweep
module attempt_driver #(
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int TGR_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       sweep_first,
   input  logic [7:0]       sweep_last,
   input  logic             tgr,
   output logic [7:0]       m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   input  logic [7:0]       s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic             busy,
   output logic             done,
   output logic [7:0]       best_attempt,
   output logic [TGR_W-1:0] best_len,
   output logic [7:0]       err_count,
   output logic             timeout_seen
);

   // Just wide enough to hold TIMEOUT_CYCLES-1, the last WAIT cycle index.
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SEND = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_EVAL = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]       state_reg;
   logic [7:0]       attempt_reg;
   logic [7:0]       last_reg;
   logic [TGR_W-1:0] tgr_cnt_reg;
   logic [TMO_W-1:0] tmo_cnt_reg;
   logic [7:0]       best_attempt_reg;
   logic [TGR_W-1:0] best_len_reg;
   logic [7:0]       err_count_reg;
   logic             timeout_seen_reg;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= S_IDLE;
         attempt_reg      <= '0;
         last_reg         <= '0;
         tgr_cnt_reg      <= '0;
         tmo_cnt_reg      <= '0;
         best_attempt_reg <= '0;
         best_len_reg     <= '0;
         err_count_reg    <= '0;
         timeout_seen_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start) begin
                  attempt_reg      <= sweep_first;
                  last_reg         <= sweep_last;
                  best_attempt_reg <= '0;
                  best_len_reg     <= '0;
                  err_count_reg    <= '0;
                  timeout_seen_reg <= 1'b0;
                  state_reg        <= S_SEND;
               end
            end
            S_SEND: begin
               if (m_axis_tready) begin
                  tgr_cnt_reg <= '0;
                  tmo_cnt_reg <= '0;
                  state_reg   <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Counters advance on every WAIT cycle, including the exit cycle.
               tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               if (tgr && (tgr_cnt_reg != {TGR_W{1'b1}})) begin
                  tgr_cnt_reg <= tgr_cnt_reg + 1'b1;
               end
               // An echo arriving on the final cycle takes priority over the timeout.
               if (s_axis_tvalid) begin
                  if (s_axis_tdata != attempt_reg) begin
                     err_count_reg <= sat_inc8(err_count_reg);
                  end
                  state_reg <= S_EVAL;
               end else if (tmo_cnt_reg == TMO_LAST) begin
                  timeout_seen_reg <= 1'b1;
                  err_count_reg    <= sat_inc8(err_count_reg);
                  state_reg        <= S_EVAL;
               end
            end
            S_EVAL: begin
               // Strict compare: on ties the earlier attempt is kept.
               if (tgr_cnt_reg > best_len_reg) begin
                  best_len_reg     <= tgr_cnt_reg;
                  best_attempt_reg <= attempt_reg;
               end
               if (attempt_reg == last_reg) begin
                  state_reg <= S_DONE;
               end else begin
                  attempt_reg <= attempt_reg + 8'd1;   // wraps 255 -> 0
                  state_reg   <= S_SEND;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Handshake and status outputs are decoded from state, so an asynchronous
   // reset drops m_axis_tvalid immediately.
   assign m_axis_tvalid = (state_reg == S_SEND);
   assign s_axis_tready = (state_reg == S_WAIT);
   assign busy          = (state_reg == S_SEND) || (state_reg == S_WAIT) || (state_reg == S_EVAL);
   assign done          = (state_reg == S_DONE);
   assign m_axis_tdata  = attempt_reg;
   assign best_attempt  = best_attempt_reg;
   assign best_len      = best_len_reg;
   assign err_count     = err_count_reg;
   assign timeout_seen  = timeout_seen_reg;

endmodule

// File: tb/tb_attempt_driver.sv
module tb_attempt_driver;

   localparam int T     = 8;
   localparam int TGR_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [7:0]       sweep_first = '0;
   logic [7:0]       sweep_last = '0;
   logic             tgr = 1'b0;
   logic [7:0]       m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready = 1'b0;
   logic [7:0]       s_axis_tdata = '0;
   logic             s_axis_tvalid = 1'b0;
   logic             s_axis_tready;
   logic             busy;
   logic             done;
   logic [7:0]       best_attempt;
   logic [TGR_W-1:0] best_len;
   logic [7:0]       err_count;
   logic             timeout_seen;

   attempt_driver #(.TIMEOUT_CYCLES(T), .TGR_W(TGR_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .sweep_first   (sweep_first),
      .sweep_last    (sweep_last),
      .tgr           (tgr),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .busy          (busy),
      .done          (done),
      .best_attempt  (best_attempt),
      .best_len      (best_len),
      .err_count     (err_count),
      .timeout_seen  (timeout_seen)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Per-attempt responder plan, indexed by attempt value.
   int plan_h[256];      // tgr high for the first h WAIT cycles
   int plan_d[256];      // WAIT cycle index at which the echo is offered; -1 = silent
   int plan_echo[256];   // echoed byte
   int plan_r[256];      // cycles of m_axis_tready low before the handshake

   // Reference results of the current sweep.
   int exp_ba, exp_bl, exp_err, exp_tmo;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_tvalid"}, 32'(m_axis_tvalid), 0);
      check({pfx, "_tdata"},  32'(m_axis_tdata), 0);
      check({pfx, "_sready"}, 32'(s_axis_tready), 0);
      check({pfx, "_busy"},   32'(busy), 0);
      check({pfx, "_done"},   32'(done), 0);
      check({pfx, "_ba"},     32'(best_attempt), 0);
      check({pfx, "_bl"},     32'(best_len), 0);
      check({pfx, "_err"},    32'(err_count), 0);
      check({pfx, "_tmo"},    32'(timeout_seen), 0);
   endtask

   task automatic set_plan(input int a, input int h, input int d, input int echo, input int r);
      plan_h[a] = h; plan_d[a] = d; plan_echo[a] = echo; plan_r[a] = r;
   endtask

   // Entered at the negedge of the first SEND cycle; leaves at the negedge after EVAL.
   task automatic do_attempt(input int a);
      int  cnt;
      bit  acc;
      int  wait_len;
      for (int i = 0; i <= plan_r[a]; i++) begin
         check("send_tvalid", 32'(m_axis_tvalid), 1);
         check("send_tdata",  32'(m_axis_tdata), 32'(a));
         check("send_sready", 32'(s_axis_tready), 0);
         check("send_busy",   32'(busy), 1);
         m_axis_tready = (i == plan_r[a]);
         tgr           = 1'($urandom_range(0, 1));
         s_axis_tvalid = ($urandom_range(0, 3) == 0);   // stray, must not be taken
         s_axis_tdata  = 8'($urandom);
         @(posedge clk); @(negedge clk);
      end
      m_axis_tready = 1'b0;
      cnt = 0;
      wait_len = 0;
      for (int idx = 0; idx < T; idx++) begin
         check("wait_sready", 32'(s_axis_tready), 1);
         check("wait_tvalid", 32'(m_axis_tvalid), 0);
         tgr = (idx < plan_h[a]);
         if (idx < plan_h[a]) cnt++;
         acc = (plan_d[a] == idx);
         s_axis_tvalid = acc;
         s_axis_tdata  = 8'(plan_echo[a]);
         // start pulses while busy must be ignored
         start       = ($urandom_range(0, 5) == 0);
         sweep_first = 8'($urandom);
         sweep_last  = 8'($urandom);
         wait_len++;
         @(posedge clk); @(negedge clk);
         if (acc) break;
      end
      start = 1'b0;
      // EVAL cycle
      check("eval_sready", 32'(s_axis_tready), 0);
      check("eval_tvalid", 32'(m_axis_tvalid), 0);
      check("eval_busy",   32'(busy), 1);
      s_axis_tvalid = ($urandom_range(0, 2) == 0);
      s_axis_tdata  = 8'($urandom);
      tgr           = 1'($urandom_range(0, 1));
      if (plan_d[a] < 0) begin
         exp_tmo = 1;
         if (exp_err < 255) exp_err++;
      end else if (plan_echo[a] != a) begin
         if (exp_err < 255) exp_err++;
      end
      if (cnt > exp_bl) begin
         exp_bl = cnt;
         exp_ba = a;
      end
      $display("attempt %02h wait=%0d tgr=%0d echo=%0s err=%0d best=%02h/%0d",
               a, wait_len, cnt, (plan_d[a] < 0) ? "none" : $sformatf("%02h", plan_echo[a]),
               exp_err, exp_ba, exp_bl);
      @(posedge clk); @(negedge clk);
      s_axis_tvalid = 1'b0;
   endtask

   // Entered and left at a negedge with the DUT in IDLE or DONE.
   task automatic run_sweep(input int f, input int l);
      int n;
      sweep_first = 8'(f);
      sweep_last  = 8'(l);
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      sweep_first = 8'($urandom);
      sweep_last  = 8'($urandom);
      exp_ba = 0; exp_bl = 0; exp_err = 0; exp_tmo = 0;
      n = ((l - f + 256) % 256) + 1;
      for (int k = 0; k < n; k++) do_attempt((f + k) % 256);
      check("done",      32'(done), 1);
      check("done_busy", 32'(busy), 0);
      check("done_tval", 32'(m_axis_tvalid), 0);
      check("best_att",  32'(best_attempt), 32'(exp_ba));
      check("best_len",  32'(best_len), 32'(exp_bl));
      check("err_count", 32'(err_count), 32'(exp_err));
      check("tmo_seen",  32'(timeout_seen), 32'(exp_tmo));
      @(posedge clk); @(negedge clk);
      check("done_hold", 32'(done), 1);
      check("err_hold",  32'(err_count), 32'(exp_err));
   endtask

   initial begin
      int f, span;
      repeat (3) @(negedge clk);
      check_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_tvalid", 32'(m_axis_tvalid), 0);

      // Three attempts, tgr windows 3/7/5
      set_plan(8'h10, 3, 4, 8'h10, 0);
      set_plan(8'h11, 7, 7, 8'h11, 1);
      set_plan(8'h12, 5, 6, 8'h12, 0);
      run_sweep(8'h10, 8'h12);
      check("t1_ba", 32'(best_attempt), 32'h11);
      check("t1_bl", 32'(best_len), 7);

      // Single attempt
      set_plan(8'hAC, 5, 5, 8'hAC, 2);
      run_sweep(8'hAC, 8'hAC);
      check("t2_bl", 32'(best_len), 5);

      // Wrap-around sweep
      set_plan(8'hFE, 2, 3, 8'hFE, 0);
      set_plan(8'hFF, 4, 5, 8'hFF, 1);
      set_plan(8'h00, 6, 6, 8'h00, 0);
      set_plan(8'h01, 1, 0, 8'h01, 2);
      run_sweep(8'hFE, 8'h01);
      check("t3_ba", 32'(best_attempt), 32'h00);

      // Silent responder -> timeout, sweep continues
      set_plan(8'h05, 9, -1, 8'h05, 0);
      set_plan(8'h06, 2, 3, 8'h06, 0);
      run_sweep(8'h05, 8'h06);
      check("t4_tmo", 32'(timeout_seen), 1);
      check("t4_err", 32'(err_count), 1);

      // Wrong echo, then echo coincident with the timeout cycle
      set_plan(8'hA5, 1, 2, 8'h5A, 0);
      run_sweep(8'hA5, 8'hA5);
      check("t5_err", 32'(err_count), 1);
      check("t5_tmo", 32'(timeout_seen), 0);
      set_plan(8'hA5, 0, T - 1, 8'hA5, 0);
      run_sweep(8'hA5, 8'hA5);
      check("t5b_err", 32'(err_count), 0);
      check("t5b_tmo", 32'(timeout_seen), 0);
      check("t5b_bl",  32'(best_len), 0);

      // Asynchronous reset in the middle of SEND
      sweep_first = 8'h30; sweep_last = 8'h31; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check("pre_rst_tvalid", 32'(m_axis_tvalid), 1);
      #2 rst_n = 1'b0;
      #1 check_zero("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_idle", 32'(m_axis_tvalid), 0);
      end
      set_plan(8'h30, 3, 4, 8'h30, 0);
      set_plan(8'h31, 2, 2, 8'h31, 0);
      run_sweep(8'h30, 8'h31);

      // Randomized sweeps
      for (int s = 0; s < 25; s++) begin
         f = $urandom_range(0, 255);
         span = $urandom_range(0, 5);
         for (int k = 0; k <= span; k++) begin
            int a;
            a = (f + k) % 256;
            set_plan(a, $urandom_range(0, 9),
                     ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, T - 1),
                     ($urandom_range(0, 5) == 0) ? (a ^ (1 << $urandom_range(0, 7))) : a,
                     $urandom_range(0, 2));
         end
         run_sweep(f, (f + span) % 256);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
